// File: rtl/mem_access_arbiter_pkg.sv
// mem_arb_pkg
// Shared definitions for the memory access arbiter: FSM state encoding,
// port identifiers, the default RAM word-address width and the
// request-to-ready latencies of each access kind (counted in clock cycles
// from the IDLE cycle in which the request is granted).
package mem_arb_pkg;

    // Default RAM word-address width (2^19 words of 32 bits).
    localparam int ADDR_W_DEF = 19;

    // Arbiter sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT0,
        WAIT1,
        DONE
    } arb_state_t;

    // Port identifiers, also used as the round-robin memory.
    typedef logic port_id_t;
    localparam port_id_t PORT_CPU = 1'b0;
    localparam port_id_t PORT_EXT = 1'b1;

    // Grant-to-ready latencies.
    localparam int LAT_REJECT     = 1;
    localparam int LAT_WRITE      = 2;
    localparam int LAT_READ       = 3;
    localparam int LAT_READ_SPLIT = 4;

endpackage

// File: rtl/mem_access_arbiter_if.sv
// mem_access_arbiter_if
// Bundles the two requester ports (CPU and external loader/debug) and the
// RAM drive/return signals of the memory access arbiter.
//   cpu_*  : byte-addressed CPU port (req/we/addr/wdata in, ready/rdata/err out)
//   ext_*  : word-addressed loader port (req/we/addr/wdata in, ready/rdata out)
//   ram_*  : registered RAM drive (addr/wdata/wren out), ram_q read data in
// Modport slave is the arbiter side, modport master is the requester/RAM side.
interface mem_access_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = 32
);

    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_err;

    logic              ext_req;
    logic              ext_we;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic              ext_ready;
    logic [DATA_W-1:0] ext_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ready, cpu_rdata, cpu_err,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_ready, ext_rdata,
        output ram_addr, ram_wdata, ram_wren,
        input  ram_q
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ready, cpu_rdata, cpu_err,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_ready, ext_rdata,
        input  ram_addr, ram_wdata, ram_wren,
        output ram_q
    );

endinterface

// File: rtl/mem_access_arbiter_word_merge.sv
// word_merge
// Combinational big-endian funnel shift used for unaligned CPU loads.
//   w0   : in  32  word holding the first addressed byte
//   w1   : in  32  following word
//   r    : in  2   byte offset into w0
//   data : out 32  upper 32 bits of {w0,w1} shifted left by 8*r
module word_merge (
    input  logic [31:0] w0,
    input  logic [31:0] w1,
    input  logic [1:0]  r,
    output logic [31:0] data
);

    logic [63:0] joined;
    logic        unused_low_bits;

    // The bytes that fall off the bottom of the 64-bit window are never
    // part of the result.
    always_comb begin
        joined = {w0, w1} << {r, 3'b000};
        data   = joined[63:32];
    end

    assign unused_low_bits = ^joined[31:0];

endmodule

// File: rtl/mem_access_arbiter.sv
// mem_access_arbiter
// Shares one single-port synchronous RAM (1-cycle read latency) between a
// CPU port and an external loader/debug port. Ties are broken round-robin.
// CPU loads may be unaligned and are assembled from two consecutive words;
// unaligned CPU stores are rejected with cpu_err.
//   clk   : in  1   clock, rising edge
//   rst_n : in  1   asynchronous active-low reset
//   bus   : mem_access_arbiter_if.slave (CPU port, ext port, RAM drive)
module mem_access_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = 32          // only 32 is supported
)(
    input  logic                 clk,
    input  logic                 rst_n,
    mem_access_arbiter_if.slave  bus
);

    arb_state_t        state;
    port_id_t          last_grant;
    port_id_t          gnt_port;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [1:0]        lat_off;
    logic [DATA_W-1:0] w0;

    port_id_t          pick;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [1:0]        sel_off;
    logic [31:0]       merged;
    logic              unused_addr_bits;

    // Bits of the CPU byte address above the RAM word address are ignored.
    assign unused_addr_bits = ^bus.cpu_addr[31:ADDR_W+2];

    // Choose the port to grant: the only requester, or on a tie the port
    // that did not win last time. Then mux that port's request fields.
    always_comb begin
        pick = PORT_CPU;
        if (bus.cpu_req && bus.ext_req) begin
            pick = (last_grant == PORT_CPU) ? PORT_EXT : PORT_CPU;
        end else if (bus.ext_req) begin
            pick = PORT_EXT;
        end

        if (pick == PORT_CPU) begin
            sel_we    = bus.cpu_we;
            sel_addr  = bus.cpu_addr[ADDR_W+1:2];
            sel_wdata = bus.cpu_wdata;
            sel_off   = bus.cpu_addr[1:0];
        end else begin
            sel_we    = bus.ext_we;
            sel_addr  = bus.ext_addr;
            sel_wdata = bus.ext_wdata;
            sel_off   = 2'b00;
        end
    end

    // Second word of an unaligned load comes straight from the RAM output.
    word_merge u_word_merge (
        .w0   (w0),
        .w1   (bus.ram_q),
        .r    (lat_off),
        .data (merged)
    );

    // Sequencer. Ready, err and wren default low every cycle so each is a
    // single-cycle pulse. The RAM address is advanced to W+1 already when
    // leaving ISSUE, so the second word arrives one cycle after the first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= PORT_EXT;
            gnt_port      <= PORT_CPU;
            lat_we        <= 1'b0;
            lat_addr      <= '0;
            lat_off       <= 2'b00;
            w0            <= '0;
            bus.cpu_ready <= 1'b0;
            bus.cpu_err   <= 1'b0;
            bus.cpu_rdata <= '0;
            bus.ext_ready <= 1'b0;
            bus.ext_rdata <= '0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
            bus.ram_wren  <= 1'b0;
        end else begin
            bus.cpu_ready <= 1'b0;
            bus.cpu_err   <= 1'b0;
            bus.ext_ready <= 1'b0;
            bus.ram_wren  <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.cpu_req || bus.ext_req) begin
                        last_grant <= pick;
                        gnt_port   <= pick;
                        lat_we     <= sel_we;
                        lat_addr   <= sel_addr;
                        lat_off    <= sel_off;
                        if (pick == PORT_CPU && sel_we && sel_off != 2'b00) begin
                            bus.cpu_ready <= 1'b1;
                            bus.cpu_err   <= 1'b1;
                            state         <= DONE;
                        end else begin
                            bus.ram_addr  <= sel_addr;
                            bus.ram_wdata <= sel_wdata;
                            bus.ram_wren  <= sel_we;
                            state         <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    if (lat_we) begin
                        if (gnt_port == PORT_CPU) begin
                            bus.cpu_ready <= 1'b1;
                        end else begin
                            bus.ext_ready <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        if (lat_off != 2'b00) begin
                            bus.ram_addr <= lat_addr + ADDR_W'(1);
                        end
                        state <= WAIT0;
                    end
                end

                WAIT0: begin
                    if (lat_off == 2'b00) begin
                        if (gnt_port == PORT_CPU) begin
                            bus.cpu_rdata <= bus.ram_q;
                            bus.cpu_ready <= 1'b1;
                        end else begin
                            bus.ext_rdata <= bus.ram_q;
                            bus.ext_ready <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        w0    <= bus.ram_q;
                        state <= WAIT1;
                    end
                end

                WAIT1: begin
                    bus.cpu_rdata <= merged;
                    bus.cpu_ready <= 1'b1;
                    state         <= DONE;
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_arbiter.sv
// tb_mem_access_arbiter
// Self-checking bench for mem_access_arbiter. A synchronous RAM model with
// one cycle read latency serves the arbiter. A transaction-level reference
// model decides grants and predicts every output cycle by cycle; directed
// transactions additionally check literal data and latency values.
module tb_mem_access_arbiter;

    localparam int ADDR_W = 19;
    localparam int WORDS  = 1 << ADDR_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mem_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(32)) bus ();

    mem_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // RAM device contents and the reference model's view of memory.
    logic [31:0] ram_mem [int];
    logic [31:0] ref_mem [int];

    function automatic logic [31:0] peek_ram(input int a);
        return ram_mem.exists(a) ? ram_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] peek_ref(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h want 0x%08h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic preload_word(input int a, input logic [31:0] d);
        ram_mem[a] = d;
        ref_mem[a] = d;
    endtask

    // Synchronous RAM: address sampled on the edge, data out one cycle later.
    always @(posedge clk) begin
        logic [31:0] q_next;
        q_next = peek_ram(int'(bus.ram_addr));
        if (bus.ram_wren) ram_mem[int'(bus.ram_addr)] = bus.ram_wdata;
        bus.ram_q <= q_next;
    end

    // Big-endian byte gather starting r bytes into word W, spilling into W+1.
    function automatic logic [31:0] model_read(input logic [31:0] byte_addr);
        int          w;
        int          r;
        logic [31:0] words [2];
        logic [31:0] res;
        w = int'(byte_addr[ADDR_W+1:2]);
        r = int'(byte_addr[1:0]);
        words[0] = peek_ref(w);
        words[1] = peek_ref((w + 1) % WORDS);
        res = 32'h0;
        for (int i = 0; i < 4; i++) begin
            int k;
            k = r + i;
            res[31 - 8*i -: 8] = words[k / 4][31 - 8*(k % 4) -: 8];
        end
        return res;
    endfunction

    // Reference model state: one outstanding transaction at a time.
    logic        m_valid    = 1'b0;
    int          m_done     = 0;
    int          m_wren_cyc = -1;
    logic        m_port     = 1'b0;
    logic        m_last     = 1'b1;
    logic        m_err      = 1'b0;
    logic        m_read     = 1'b0;
    logic [31:0] m_data     = 32'h0;
    logic [31:0] m_waddr    = 32'h0;
    logic [31:0] m_wdata    = 32'h0;

    // Grant decision and outcome prediction, evaluated on each rising edge
    // with the request inputs of the cycle that is ending.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid    = 1'b0;
            m_last     = 1'b1;
            m_wren_cyc = -1;
        end else if (!m_valid || cyc > m_done) begin
            m_valid    = 1'b0;
            m_wren_cyc = -1;
            if (bus.cpu_req || bus.ext_req) begin
                if (bus.cpu_req && bus.ext_req) m_port = ~m_last;
                else                            m_port = bus.ext_req;
                m_last  = m_port;
                m_valid = 1'b1;
                m_err   = 1'b0;
                if (m_port == 1'b0) begin
                    m_read = !bus.cpu_we;
                    if (bus.cpu_we && bus.cpu_addr[1:0] != 2'b00) begin
                        m_err  = 1'b1;
                        m_done = cyc + 1;
                    end else if (bus.cpu_we) begin
                        m_waddr = 32'(bus.cpu_addr[ADDR_W+1:2]);
                        m_wdata = bus.cpu_wdata;
                        ref_mem[int'(m_waddr)] = m_wdata;
                        m_wren_cyc = cyc + 1;
                        m_done     = cyc + 2;
                    end else begin
                        m_data = model_read(bus.cpu_addr);
                        m_done = cyc + ((bus.cpu_addr[1:0] == 2'b00) ? 3 : 4);
                    end
                end else begin
                    m_read = !bus.ext_we;
                    if (bus.ext_we) begin
                        m_waddr = 32'(bus.ext_addr);
                        m_wdata = bus.ext_wdata;
                        ref_mem[int'(m_waddr)] = m_wdata;
                        m_wren_cyc = cyc + 1;
                        m_done     = cyc + 2;
                    end else begin
                        m_data = model_read(32'(bus.ext_addr) << 2);
                        m_done = cyc + 3;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    logic [31:0] exp_cpu_rdata = 32'h0;
    logic [31:0] exp_ext_rdata = 32'h0;

    always @(negedge clk) begin
        logic e_cr, e_er, e_err, e_wren;
        if (!rst_n) begin
            exp_cpu_rdata = 32'h0;
            exp_ext_rdata = 32'h0;
            e_cr   = 1'b0;
            e_er   = 1'b0;
            e_err  = 1'b0;
            e_wren = 1'b0;
            check_output("rst ram_addr", 32'(bus.ram_addr), 32'h0);
            check_output("rst ram_wdata", bus.ram_wdata, 32'h0);
        end else begin
            e_cr   = m_valid && cyc == m_done && m_port == 1'b0;
            e_er   = m_valid && cyc == m_done && m_port == 1'b1;
            e_err  = e_cr && m_err;
            e_wren = m_valid && cyc == m_wren_cyc;
            if (e_cr && m_read) exp_cpu_rdata = m_data;
            if (e_er && m_read) exp_ext_rdata = m_data;
        end
        check_output("cpu_ready", 32'(bus.cpu_ready), 32'(e_cr));
        check_output("ext_ready", 32'(bus.ext_ready), 32'(e_er));
        check_output("cpu_err", 32'(bus.cpu_err), 32'(e_err));
        check_output("ram_wren", 32'(bus.ram_wren), 32'(e_wren));
        check_output("cpu_rdata", bus.cpu_rdata, exp_cpu_rdata);
        check_output("ext_rdata", bus.ext_rdata, exp_ext_rdata);
        if (e_wren) begin
            check_output("ram_addr", 32'(bus.ram_addr), m_waddr);
            check_output("ram_wdata", bus.ram_wdata, m_wdata);
        end
    end

    // One complete access on a port; returns data, err and grant-to-ready
    // latency (-1 on timeout). Address and data are scrambled after grant.
    task automatic apply_stimulus(input logic port, input logic we,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rdata, output logic err,
                                  output int lat);
        int g;
        @(posedge clk);
        #1;
        g     = cyc;
        lat   = -1;
        rdata = 32'h0;
        err   = 1'b0;
        if (port == 1'b0) begin
            bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_req = 1'b1;
        end else begin
            bus.ext_we = we; bus.ext_addr = addr[ADDR_W-1:0]; bus.ext_wdata = wdata; bus.ext_req = 1'b1;
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (port == 1'b0 && bus.cpu_ready) begin
                lat = cyc - g; rdata = bus.cpu_rdata; err = bus.cpu_err;
                break;
            end
            if (port == 1'b1 && bus.ext_ready) begin
                lat = cyc - g; rdata = bus.ext_rdata;
                break;
            end
            bus.cpu_addr  = bus.cpu_addr ^ 32'h0000_0107;
            bus.cpu_wdata = ~bus.cpu_wdata;
            bus.ext_addr  = bus.ext_addr ^ 19'h00041;
            bus.ext_wdata = ~bus.ext_wdata;
        end
        bus.cpu_req = 1'b0;
        bus.ext_req = 1'b0;
        check_output("completed", 32'(lat >= 0), 32'h1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          seen;
        int          g;
        int          n;
        int          order [3];
        int          when [3];

        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0; bus.cpu_wdata = 32'h0;
        bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = '0;    bus.ext_wdata = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset cpu_ready", 32'(bus.cpu_ready), 32'h0);
        check_output("reset cpu_rdata", bus.cpu_rdata, 32'h0);
        check_output("reset ram_wren", 32'(bus.ram_wren), 32'h0);
        rst_n = 1'b1;

        preload_word(4, 32'h11223344);
        preload_word(5, 32'h55667788);
        preload_word(WORDS - 1, 32'hAABBCCDD);
        preload_word(0, 32'h01020304);

        $display("[TB] unaligned load");
        apply_stimulus(1'b0, 1'b0, 32'h0000_0012, 32'h0, rd, er, lat);
        check_output("unaligned load data", rd, 32'h33445566);
        check_output("unaligned load latency", 32'(lat), 32'd4);

        $display("[TB] unaligned store rejected");
        apply_stimulus(1'b0, 1'b1, 32'h0000_0013, 32'hFFFF_FFFF, rd, er, lat);
        check_output("reject err", 32'(er), 32'h1);
        check_output("reject latency", 32'(lat), 32'd1);
        check_output("reject word4 intact", peek_ram(4), 32'h11223344);

        $display("[TB] aligned store then load");
        apply_stimulus(1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, rd, er, lat);
        check_output("store latency", 32'(lat), 32'd2);
        check_output("store err", 32'(er), 32'h0);
        check_output("store ram word4", peek_ram(4), 32'hDEADBEEF);
        apply_stimulus(1'b0, 1'b0, 32'h0000_0010, 32'h0, rd, er, lat);
        check_output("load data", rd, 32'hDEADBEEF);
        check_output("load latency", 32'(lat), 32'd3);

        $display("[TB] offset 3 load");
        apply_stimulus(1'b0, 1'b0, 32'h0000_0013, 32'h0, rd, er, lat);
        check_output("offset3 data", rd, 32'hEF556677);

        $display("[TB] wrap-around load");
        apply_stimulus(1'b0, 1'b0, 32'h001F_FFFD, 32'h0, rd, er, lat);
        check_output("wrap data", rd, 32'hBBCCDD01);
        check_output("wrap latency", 32'(lat), 32'd4);

        $display("[TB] ext port write/read");
        apply_stimulus(1'b1, 1'b1, 32'h0000_0100, 32'hCAFEF00D, rd, er, lat);
        check_output("ext store latency", 32'(lat), 32'd2);
        apply_stimulus(1'b1, 1'b0, 32'h0000_0100, 32'h0, rd, er, lat);
        check_output("ext load data", rd, 32'hCAFEF00D);
        check_output("ext load latency", 32'(lat), 32'd3);
        apply_stimulus(1'b0, 1'b0, 32'h0000_0400, 32'h0, rd, er, lat);
        check_output("cpu sees ext data", rd, 32'hCAFEF00D);

        $display("[TB] reset during read");
        @(posedge clk); #1;
        bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_0014; bus.cpu_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.cpu_req = 1'b0;
        #1;
        check_output("midrst cpu_rdata", bus.cpu_rdata, 32'h0);
        check_output("midrst ext_rdata", bus.ext_rdata, 32'h0);
        check_output("midrst ram_addr", 32'(bus.ram_addr), 32'h0);
        check_output("midrst cpu_ready", 32'(bus.cpu_ready), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (bus.cpu_ready) seen++;
        end
        check_output("no ready after reset", 32'(seen), 32'h0);
        apply_stimulus(1'b0, 1'b0, 32'h0000_0014, 32'h0, rd, er, lat);
        check_output("post-reset load data", rd, 32'h55667788);
        check_output("post-reset load latency", 32'(lat), 32'd3);

        $display("[TB] simultaneous requests after reset");
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        g = cyc;
        order = '{9, 9, 9};
        when  = '{0, 0, 0};
        n = 0;
        bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0000_0014; bus.cpu_req = 1'b1;
        bus.ext_we = 1'b0; bus.ext_addr = 19'd4;         bus.ext_req = 1'b1;
        for (int i = 0; i < 40 && n < 3; i++) begin
            @(posedge clk); #1;
            if (bus.cpu_ready) begin
                order[n] = 0; when[n] = cyc; n++;
            end else if (bus.ext_ready) begin
                order[n] = 1; when[n] = cyc; n++;
            end
        end
        bus.cpu_req = 1'b0;
        bus.ext_req = 1'b0;
        check_output("tie grant count", 32'(n), 32'd3);
        check_output("tie first cpu", 32'(order[0]), 32'd0);
        check_output("tie second ext", 32'(order[1]), 32'd1);
        check_output("tie third cpu", 32'(order[2]), 32'd0);
        check_output("tie first latency", 32'(when[0] - g), 32'd3);
        check_output("tie spacing", 32'(when[1] - when[0]), 32'd4);
        check_output("tie cpu data", bus.cpu_rdata, 32'h55667788);
        check_output("tie ext data", bus.ext_rdata, 32'hDEADBEEF);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_arbiter.md
MEM_ACCESS_ARBITER -- requirements
Module: mem_access_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 19: RAM word-address width.
REQ-002 SHALL have parameter DATA_W, default 32: RAM word width; only 32 is supported.
REQ-003 SHALL have port clk  in  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-005 SHALL have port cpu_req  in  1: CPU request; held high until cpu_ready.
REQ-006 SHALL have port cpu_we  in  1: 1 = store, 0 = load; stable while cpu_req is high.
REQ-007 SHALL have port cpu_addr  in  32: byte address; bits [ADDR_W+1:2] form the word address and bits [1:0] the byte offset; upper bits are ignored.
REQ-008 SHALL have port cpu_wdata  in  32: store data.
REQ-009 SHALL have port cpu_ready  out  1: one-cycle completion pulse.
REQ-010 SHALL have port cpu_rdata  out  32: load data, valid while cpu_ready is high and held until the next CPU load.
REQ-011 SHALL have port cpu_err  out  1: pulses with cpu_ready on a rejected access.
REQ-012 SHALL have port ext_req/ext_we  in  1/1: loader/debug port request and write enable; same rules as the CPU port.
REQ-013 SHALL have port ext_addr  in  ADDR_W: word address; ext accesses are always aligned.
REQ-014 SHALL have ports ext_wdata  in  32, ext_ready  out  1 and ext_rdata  out  32: same rules as the CPU port.
REQ-015 SHALL have ports ram_addr  out  ADDR_W, ram_wdata  out  32 and ram_wren  out  1: registered RAM drive signals.
REQ-016 SHALL have port ram_q  in  32: RAM read data, valid in the cycle after ram_addr was sampled (1-cycle latency).

Function
REQ-017 SHALL implement FSM states IDLE, ISSUE, WAIT0, WAIT1, DONE.
REQ-018 SHALL grant in IDLE when any req is high; if both are high, the port opposite last_grant wins (round-robin); last_grant updates on grant.
REQ-019 SHALL latch the granted port's we, address and wdata at grant; later input changes are ignored until DONE.
REQ-020 SHALL reject a CPU store with cpu_addr[1:0] != 0: go IDLE->DONE, pulse cpu_ready and cpu_err together, never assert ram_wren.
REQ-021 SHALL handle a write as IDLE->ISSUE (ram_wren=1 for exactly one cycle with latched address/data)->DONE, giving ready 2 cycles after grant.
REQ-022 SHALL handle an aligned read as IDLE->ISSUE->WAIT0 (capture ram_q)->DONE, giving ready 3 cycles after grant.
REQ-023 SHALL handle an unaligned CPU read with offset r as follows: ISSUE reads word W, WAIT0 captures w0 and drives W+1, WAIT1 captures w1, then DONE; ready comes 4 cycles after grant.
REQ-024 SHALL compute unaligned read data big-endian as the upper 32 bits of {w0,w1} shifted left by 8*r (r=1: {w0[23:0],w1[31:24]}).
REQ-025 SHALL wrap W+1 modulo 2^ADDR_W (0x7FFFF -> 0x00000).
REQ-026 SHALL, in DONE, pulse only the granted port's ready, update only that port's rdata on a read, then return to IDLE.
REQ-027 SHALL treat a req still high in the IDLE cycle after DONE as a new request.
REQ-028 SHALL keep ram_wren at 0 in every state except ISSUE of a write.

Reset
REQ-029 SHALL on rst_n low, regardless of the clock, force state=IDLE, last_grant=ext (so the CPU wins the first tie), and set all ready/err/rdata/ram_* outputs to 0.
REQ-030 SHALL, on reset mid-transaction, drop the transaction with no ready pulse; a write already in ISSUE may have completed in the RAM.

Structure
REQ-031 SHALL place in package mem_arb_pkg: the state enum, port-ID constants (PORT_CPU, PORT_EXT), the ADDR_W default and the latency constants.
REQ-032 SHALL implement the funnel shift as combinational sub-module word_merge (w0, w1, r -> 32-bit data).

Verification
REQ-033 SHALL cover an aligned CPU store then load: store 0x00000010 <- 0xDEADBEEF, then load from it; cpu_ready arrives 2 and 3 cycles after grant, cpu_rdata=0xDEADBEEF.
REQ-034 SHALL cover an unaligned load: word 4=0x11223344 and word 5=0x55667788, load at 0x00000012; result is 0x33445566, ready 4 cycles after grant.
REQ-035 SHALL cover an unaligned store to 0x00000013: cpu_ready and cpu_err pulse together, ram_wren stays 0 and word 4 is unchanged.
REQ-036 SHALL cover simultaneous requests after reset: the CPU is served first, then ext; with both held, grants alternate CPU, ext, CPU.
REQ-037 SHALL cover wrap-around: word 0x7FFFF=0xAABBCCDD and word 0=0x01020304, load at byte 0x001FFFFD; result is 0xBBCCDD01.
REQ-038 SHALL cover reset mid-operation: rst_n pulsed low in WAIT0 of a read gives no ready, all outputs 0 immediately, and a new request completes normally afterwards.
